lcd_frame_composer: RTL and testbench

Sequential frame builder between game logic and the text-LCD driver. On each frame request it snapshots the display mode, the 16-cell obstacle map, the dino ground flag and the score. It then builds the two 16-character LCD lines column by column into a shadow buffer and commits both lines to its outputs atomically. The outputs drive the TEXT_STRING_UPPER/LOWER inputs of the LCD controller directly, replacing the combinational string mux in the top level.

---
 rtl/lcd_frame_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 47 ++++
 rtl/lcd_frame_composer.sv | 120 ++++++++++++
 tb/tb_lcd_frame_composer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_frame_pkg.sv
// Shared types and constants for the LCD frame composer: mode/char codes,
// FSM encoding, fixed screen strings and a column byte selector.
package lcd_frame_pkg;
  localparam int COLS      = 16;
  localparam int SCORE_MAX = 99999;
  localparam int LINE_W    = COLS * 8;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'd0,
    MODE_MENU = 2'd1,
    MODE_GAME = 2'd2,
    MODE_OVER = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef struct packed {
    mode_e       mode;
    logic [31:0] map;
    logic        on_ground;
  } snap_t;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_DINO_GND = 8'h00;
  localparam logic [7:0] CH_DINO_AIR = 8'h03;
  localparam logic [7:0] CH_OBST     = 8'h04;
  localparam logic [3:0] ASCII_DIGIT = 4'h3;

  localparam logic [LINE_W-1:0] LINE_BLANK  = {COLS{CH_SPACE}};
  localparam logic [LINE_W-1:0] STR_LOAD    = "LOADING FONTS...";
  localparam logic [LINE_W-1:0] STR_MENU_UP = "    PRESS ANY KE";
  localparam logic [LINE_W-1:0] STR_MENU_LO = {CH_DINO_GND, "  TO START GAME"};
  localparam logic [87:0]       STR_OVER    = "GAME OVER  ";

  // Column 0 lives in the top byte of a line.
  function automatic logic [7:0] line_char(input logic [LINE_W-1:0] line,
                                           input logic [3:0] col);
    logic [6:0] lsb;
    lsb = 7'(LINE_W - 8) - {col, 3'b000};
    return line[lsb +: 8];
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to 5-digit BCD converter, one bit per cycle.
module bin2bcd_seq
  import lcd_frame_pkg::*;
#(
  parameter int BIN_W = 17
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [19:0]      bcd
);
  localparam int CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic [19:0]      adj;

  for (genvar d = 0; d < 5; d++) begin : g_adj
    assign adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3
                                                   : bcd[4*d +: 4];
  end

  // High during the cycle whose edge performs the final shift.
  assign done = active && (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      bcd    <= '0;
    end else if (start) begin
      sh     <= bin;
      cnt    <= '0;
      active <= 1'b1;
      bcd    <= '0;
    end else if (active) begin
      bcd <= {adj[18:0], sh[BIN_W-1]};
      sh  <= sh << 1;
      cnt <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end
endmodule

// File: rtl/lcd_frame_composer.sv
// Snapshots game state on request, builds both LCD lines one column per cycle
// into a shadow buffer, then commits them to the outputs in a single edge.
module lcd_frame_composer #(
  parameter int COLS      = 16,
  parameter int SCORE_MAX = 99999,
  parameter int BIN_W     = 17
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              frame_req,
  input  logic [1:0]        mode,
  input  logic [31:0]       obstacle_map_flat,
  input  logic              dino_on_ground,
  input  logic [31:0]       score,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_drop,
  output logic [COLS*8-1:0] text_upper,
  output logic [COLS*8-1:0] text_lower
);
  import lcd_frame_pkg::*;

  localparam int CW = $clog2(COLS);

  state_e                 state, state_nx;
  snap_t                  snap;
  logic [CW-1:0]          col;
  logic [COLS-1:0][7:0]   sh_up, sh_lo;
  logic                   accept, conv_start, conv_done;
  logic [BIN_W-1:0]       score_sat;
  logic [19:0]            bcd;
  logic [COLS*8-1:0]      over_up;
  logic [7:0]             ch_up, ch_lo;

  assign accept     = frame_req && (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign conv_start = accept && (mode == MODE_OVER);
  assign score_sat  = (score > 32'(SCORE_MAX)) ? BIN_W'(SCORE_MAX) : score[BIN_W-1:0];

  bin2bcd_seq #(.BIN_W(BIN_W)) u_bcd (
    .CLK  (CLK),
    .RST  (RST),
    .start(conv_start),
    .bin  (score_sat),
    .done (conv_done),
    .bcd  (bcd)
  );

  assign over_up = {STR_OVER,
                    ASCII_DIGIT, bcd[19:16], ASCII_DIGIT, bcd[15:12],
                    ASCII_DIGIT, bcd[11:8],  ASCII_DIGIT, bcd[7:4],
                    ASCII_DIGIT, bcd[3:0]};

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (frame_req) state_nx = (mode == MODE_OVER) ? ST_CONV : ST_FILL;
      ST_CONV:   if (conv_done) state_nx = ST_FILL;
      ST_FILL:   if (col == CW'(COLS - 1)) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Character pair for the current column, from the snapshot only.
  always_comb begin
    ch_up = CH_SPACE;
    ch_lo = CH_SPACE;
    case (snap.mode)
      MODE_LOAD: ch_up = line_char(STR_LOAD, col);
      MODE_MENU: begin
        ch_up = line_char(STR_MENU_UP, col);
        ch_lo = line_char(STR_MENU_LO, col);
      end
      MODE_GAME: begin
        if (col == '0 && !snap.on_ground) ch_up = CH_DINO_AIR;
        if (snap.map[{col, 1'b0} +: 2] != 2'b00) ch_lo = CH_OBST;
        else if (col == '0 && snap.on_ground) ch_lo = CH_DINO_GND;
      end
      MODE_OVER: begin
        ch_up = line_char(over_up, col);
        if (col == '0) ch_lo = CH_OBST;
        else if (col == CW'(10)) ch_lo = CH_DINO_AIR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      col        <= '0;
      snap       <= '0;
      sh_up      <= LINE_BLANK;
      sh_lo      <= LINE_BLANK;
      text_upper <= LINE_BLANK;
      text_lower <= LINE_BLANK;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      if (frame_req && busy) frame_drop <= 1'b1;
      if (accept) begin
        snap <= '{mode: mode_e'(mode), map: obstacle_map_flat, on_ground: dino_on_ground};
        col  <= '0;
      end
      if (state == ST_FILL) begin
        sh_up[CW'(COLS - 1) - col] <= ch_up;
        sh_lo[CW'(COLS - 1) - col] <= ch_lo;
        col <= col + 1'b1;
      end
      if (state == ST_COMMIT) begin
        text_upper <= sh_up;
        text_lower <= sh_lo;
        frame_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_frame_composer.sv
// Randomized bench for lcd_frame_composer against a string-level screen model.
module tb_lcd_frame_composer;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         frame_req = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [31:0]  obstacle_map_flat = '0;
  logic         dino_on_ground = 1'b0;
  logic [31:0]  score = '0;
  logic         busy, frame_done, frame_drop;
  logic [127:0] text_upper, text_lower;

  int  total = 0;
  int  bad = 0;
  bit  exp_drop = 1'b0;
  localparam logic [127:0] BLANK = {16{8'h20}};

  lcd_frame_composer dut (
    .CLK(CLK), .RST(RST), .frame_req(frame_req), .mode(mode),
    .obstacle_map_flat(obstacle_map_flat), .dino_on_ground(dino_on_ground),
    .score(score), .busy(busy), .frame_done(frame_done), .frame_drop(frame_drop),
    .text_upper(text_upper), .text_lower(text_lower)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Screen model: each line as 16 characters, column 0 first.
  function automatic logic [127:0] model_line(input bit up, input logic [1:0] m,
      input logic [31:0] mp, input logic g, input logic [31:0] sc);
    string s;
    logic [7:0] b [16];
    logic [127:0] r;
    int v;
    for (int i = 0; i < 16; i++) b[i] = 8'h20;
    case (m)
      2'd0: if (up) begin
        s = "LOADING FONTS...";
        for (int i = 0; i < 16; i++) b[i] = s[i];
      end
      2'd1: if (up) begin
        s = "    PRESS ANY KE";
        for (int i = 0; i < 16; i++) b[i] = s[i];
      end else begin
        s = "  TO START GAME";
        b[0] = 8'h00;
        for (int i = 1; i < 16; i++) b[i] = s[i-1];
      end
      2'd2: if (up) begin
        if (!g) b[0] = 8'h03;
      end else begin
        if (g) b[0] = 8'h00;
        for (int i = 0; i < 16; i++)
          if (((mp >> (2*i)) & 32'd3) != 32'd0) b[i] = 8'h04;
      end
      default: if (up) begin
        s = "GAME OVER  ";
        for (int i = 0; i < 11; i++) b[i] = s[i];
        v = (sc > 32'd99999) ? 99999 : int'(sc);
        for (int k = 0; k < 5; k++) begin
          b[15-k] = 8'h30 + 8'(v % 10);
          v = v / 10;
        end
      end else begin
        b[0]  = 8'h04;
        b[10] = 8'h03;
      end
    endcase
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], b[i]};
    return r;
  endfunction

  // Called at a negedge; leaves the bench at the negedge where frame_done was seen.
  task automatic run_frame(input logic [1:0] m, input logic [31:0] mp, input logic g,
                           input logic [31:0] sc, input bit perturb, input bit dup);
    logic [127:0] eu, el, pu, pl;
    int lat, j, done_j, busy_n;
    bit changed;
    eu = model_line(1'b1, m, mp, g, sc);
    el = model_line(1'b0, m, mp, g, sc);
    lat = (m == 2'd3) ? 34 : 17;
    pu = text_upper;
    pl = text_lower;
    mode = m; obstacle_map_flat = mp; dino_on_ground = g; score = sc;
    frame_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    frame_req = 1'b0;
    chk("done_low_after_accept", 128'(frame_done), 128'(0));
    j = 0; done_j = -1; busy_n = 0; changed = 1'b0;
    while (j < lat + 10) begin
      if (busy) busy_n++;
      if (perturb && j == 2) begin
        mode = 2'($urandom_range(0, 3));
        obstacle_map_flat = $urandom;
        dino_on_ground = ~dino_on_ground;
        score = $urandom;
      end
      if (dup && j == 4) begin
        frame_req = 1'b1;
        exp_drop = 1'b1;
      end
      @(posedge CLK);
      j++;
      @(negedge CLK);
      frame_req = 1'b0;
      if (frame_done) begin
        done_j = j;
        break;
      end
      if (text_upper !== pu || text_lower !== pl) changed = 1'b1;
    end
    chk("latency", 128'(done_j), 128'(lat));
    chk("busy_cycles", 128'(busy_n), 128'(lat));
    chk("busy_after_commit", 128'(busy), 128'(0));
    chk("stable_before_commit", 128'(changed), 128'(0));
    chk("upper", text_upper, eu);
    chk("lower", text_lower, el);
    chk("drop", 128'(frame_drop), 128'(exp_drop));
  endtask

  task automatic reset_mid_build();
    int dones;
    mode = 2'd2; obstacle_map_flat = 32'h0000_0005; dino_on_ground = 1'b1; score = '0;
    frame_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    frame_req = 1'b0;
    for (int j = 0; j < 7; j++) @(negedge CLK);
    RST = 1'b1;
    exp_drop = 1'b0;
    #1;
    chk("rst_upper", text_upper, BLANK);
    chk("rst_lower", text_lower, BLANK);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(frame_done), 128'(0));
    chk("rst_drop", 128'(frame_drop), 128'(0));
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge CLK);
      if (frame_done) dones++;
    end
    chk("no_done_after_abort", 128'(dones), 128'(0));
  endtask

  initial begin
    logic [31:0] sc;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_upper", text_upper, BLANK);
    chk("reset_lower", text_lower, BLANK);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(frame_done), 128'(0));
    chk("reset_drop", 128'(frame_drop), 128'(0));
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    run_frame(2'd2, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0);
    run_frame(2'd2, 32'h4000_0001, 1'b1, 32'd0, 1'b0, 1'b0);
    run_frame(2'd2, 32'h4000_0001, 1'b0, 32'd0, 1'b0, 1'b0);
    run_frame(2'd0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
    run_frame(2'd1, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0);
    run_frame(2'd3, 32'h0, 1'b0, 32'd42, 1'b0, 1'b0);
    run_frame(2'd3, 32'h0, 1'b0, 32'd123456, 1'b0, 1'b0);
    run_frame(2'd3, 32'h0, 1'b0, 32'd99999, 1'b0, 1'b0);
    run_frame(2'd3, 32'h0, 1'b0, 32'd100000, 1'b0, 1'b0);
    run_frame(2'd2, 32'h0000_3c0c, 1'b1, 32'd0, 1'b1, 1'b0);
    run_frame(2'd2, 32'h0000_0002, 1'b0, 32'd0, 1'b0, 1'b1);
    run_frame(2'd1, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0);

    reset_mid_build();
    run_frame(2'd2, 32'h8000_0003, 1'b1, 32'd0, 1'b0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0:       sc = $urandom;
        1:       sc = 32'($urandom_range(99990, 100010));
        default: sc = 32'($urandom_range(0, 99999));
      endcase
      run_frame(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), sc,
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
